// File: rtl/ecall_io_unit.sv
// ecall_io_unit: environment-call I/O controller that sits beside the ALU in EX.
//
// Services ecall codes taken from a7 using a0 as the argument:
//   1  print           : seg_data <= a0, completes with no write-back
//   5  read unsigned   : waits for a fresh button press, returns the switches zero-extended
//   6  read signed     : as 5, sign-extended from the top switch bit
//   10 exit            : parks in HALT until rst (ecall_done never asserts)
//   30 read cycles     : only with CYCLE_COUNTER_EN defined; returns the free-running counter
//   other              : sets sticky bad_ecall, completes with no write-back
//
// Optional feature macro: CYCLE_COUNTER_EN (adds the cycle counter and code 30).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ecall, a0, a7          request from EX; ecall held until ecall_done
//   switches, button       raw asynchronous inputs (synchronised and debounced here)
//   ecall_done             one-cycle completion pulse
//   ecall_write            one-cycle pulse with ecall_done when a0 is written back
//   ecall_result           write-back value, held between pulses
//   seg_data               value held for the seven-segment driver
//   busy, halted, bad_ecall  status (halted and bad_ecall are sticky)
module ecall_io_unit #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SW_WIDTH        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ecall,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] a7,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  button,
    output logic                  ecall_done,
    output logic                  ecall_write,
    output logic [DATA_WIDTH-1:0] ecall_result,
    output logic [DATA_WIDTH-1:0] seg_data,
    output logic                  busy,
    output logic                  halted,
    output logic                  bad_ecall
);

    localparam int unsigned IN_W  = SW_WIDTH + 1;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] SvcPrint = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] SvcReadU = DATA_WIDTH'(5);
    localparam logic [DATA_WIDTH-1:0] SvcReadS = DATA_WIDTH'(6);
    localparam logic [DATA_WIDTH-1:0] SvcExit  = DATA_WIDTH'(10);
`ifdef CYCLE_COUNTER_EN
    localparam logic [DATA_WIDTH-1:0] SvcCycles = DATA_WIDTH'(30);
`endif

    typedef enum logic [2:0] {StIdle, StWaitBtn, StDone, StRelease, StHalt} state_e;

    // Input path: bit SW_WIDTH is the button, the rest are the switches.
    logic [IN_W-1:0] raw_in;
    logic [IN_W-1:0] meta_q;
    logic [IN_W-1:0] sync_q;
    logic [IN_W-1:0] deb_lvl;

    assign raw_in = {button, switches};

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_in;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < IN_W; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;

        // Count consecutive mismatching cycles; a matching cycle restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (sync_q[i] != level_q) begin
                if (cnt_q == CntLast) begin
                    cnt_q   <= '0;
                    level_q <= sync_q[i];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign deb_lvl[i] = level_q;
    end

    logic                btn_lvl;
    logic                btn_prev_q;
    logic                btn_rise;
    logic [SW_WIDTH-1:0] sw_lvl;

    assign btn_lvl  = deb_lvl[SW_WIDTH];
    assign sw_lvl   = deb_lvl[SW_WIDTH-1:0];
    assign btn_rise = btn_lvl & ~btn_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_lvl;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [DATA_WIDTH-1:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + DATA_WIDTH'(1);
        end
    end
`endif

    // Read value: zero-extended, then the upper bits overwritten with the sign for code 6.
    logic                  read_signed_q;
    logic [DATA_WIDTH-1:0] read_val;

    always_comb begin
        read_val = DATA_WIDTH'(sw_lvl);
        if (read_signed_q) begin
            for (int unsigned i = SW_WIDTH; i < DATA_WIDTH; i++) begin
                read_val[i] = sw_lvl[SW_WIDTH-1];
            end
        end
    end

    state_e state_q;

    // Outputs are registered alongside the state; ecall_done/ecall_write are set on the
    // transition into StDone so they are high exactly while the FSM sits in StDone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            read_signed_q <= 1'b0;
            ecall_done    <= 1'b0;
            ecall_write   <= 1'b0;
            ecall_result  <= '0;
            seg_data      <= '0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            bad_ecall     <= 1'b0;
        end else begin
            ecall_done  <= 1'b0;
            ecall_write <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ecall) begin
                        busy <= 1'b1;
                        if (a7 == SvcPrint) begin
                            seg_data   <= a0;
                            ecall_done <= 1'b1;
                            state_q    <= StDone;
                        end else if (a7 == SvcReadU || a7 == SvcReadS) begin
                            read_signed_q <= (a7 == SvcReadS);
                            state_q       <= StWaitBtn;
                        end else if (a7 == SvcExit) begin
                            halted  <= 1'b1;
                            state_q <= StHalt;
`ifdef CYCLE_COUNTER_EN
                        end else if (a7 == SvcCycles) begin
                            ecall_result <= cycle_cnt_q;
                            ecall_done   <= 1'b1;
                            ecall_write  <= 1'b1;
                            state_q      <= StDone;
`endif
                        end else begin
                            bad_ecall  <= 1'b1;
                            ecall_done <= 1'b1;
                            state_q    <= StDone;
                        end
                    end
                end
                StWaitBtn: begin
                    // A button already held on entry shows no rise here, so it must be re-pressed.
                    if (btn_rise) begin
                        ecall_result <= read_val;
                        seg_data     <= read_val;
                        ecall_done   <= 1'b1;
                        ecall_write  <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    if (!ecall) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecall_io_unit.sv
// tb_ecall_io_unit: randomized self-checking bench for ecall_io_unit (DEBOUNCE_CYCLES = 4).
module tb_ecall_io_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ecall = 1'b0;
    logic [DW-1:0] a0 = '0;
    logic [DW-1:0] a7 = '0;
    logic [SW-1:0] switches = '0;
    logic          button = 1'b0;
    logic          ecall_done;
    logic          ecall_write;
    logic [DW-1:0] ecall_result;
    logic [DW-1:0] seg_data;
    logic          busy;
    logic          halted;
    logic          bad_ecall;

    ecall_io_unit #(
        .DATA_WIDTH      (DW),
        .SW_WIDTH        (SW),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ecall        (ecall),
        .a0           (a0),
        .a7           (a7),
        .switches     (switches),
        .button       (button),
        .ecall_done   (ecall_done),
        .ecall_write  (ecall_write),
        .ecall_result (ecall_result),
        .seg_data     (seg_data),
        .busy         (busy),
        .halted       (halted),
        .bad_ecall    (bad_ecall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: counts completion pulses in the middle of each cycle.
    int            done_cnt  = 0;
    int            write_cnt = 0;
    int            orphan_write = 0;
    logic [DW-1:0] last_result = '0;

    always @(negedge clk) begin
        if (ecall_done === 1'b1) done_cnt <= done_cnt + 1;
        if (ecall_write === 1'b1) begin
            write_cnt   <= write_cnt + 1;
            last_result <= ecall_result;
            if (ecall_done !== 1'b1) orphan_write <= orphan_write + 1;
        end
    end

    // Reference cycle count: edges since the last reset edge.
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Expected values of the held outputs.
    logic [DW-1:0] exp_seg = '0;
    logic [DW-1:0] exp_res = '0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] read_model(input int code, input logic [SW-1:0] sw);
        int unsigned v;
        v = sw;
        if (code == 6 && sw >= 8'd128) v = v + 32'hFFFF_FF00;
        return v;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        ecall = 1'b0;
        button = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_seg = '0;
        exp_res = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (ecall_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", ecall_done); end
        n_checks++; if (ecall_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b, expected 0", ecall_write); end
        n_checks++; if (ecall_result !== '0) begin n_fail++; $display("FAIL reset_result: got %h, expected 0", ecall_result); end
        n_checks++; if (seg_data !== '0) begin n_fail++; $display("FAIL reset_seg: got %h, expected 0", seg_data); end
        n_checks++; if ({busy, halted, bad_ecall} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b, expected 000", {busy, halted, bad_ecall}); end
    endtask

    task automatic test_print(input logic [DW-1:0] val);
        int base;
        base = done_cnt;
        a7 = 32'd1;
        a0 = val;
        ecall = 1'b1;
        tick(1);
        exp_seg = val;
        a0 = DW'($urandom);  // ignored while busy
        n_checks++; if (ecall_done !== 1'b1) begin n_fail++; $display("FAIL print_done: got %b, expected 1", ecall_done); end
        n_checks++; if (ecall_write !== 1'b0) begin n_fail++; $display("FAIL print_write: got %b, expected 0", ecall_write); end
        n_checks++; if (seg_data !== exp_seg) begin n_fail++; $display("FAIL print_seg: got %h, expected %h", seg_data, exp_seg); end
        tick(3);
        n_checks++; if (done_cnt - base !== 1) begin n_fail++; $display("FAIL print_single_done: got %0d, expected 1", done_cnt - base); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL print_busy_held: got %b, expected 1", busy); end
        ecall = 1'b0;
        tick(2);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL print_idle: got %b, expected 0", busy); end
        n_checks++; if (ecall_result !== exp_res) begin n_fail++; $display("FAIL print_result_hold: got %h, expected %h", ecall_result, exp_res); end
    endtask

    task automatic test_read(input int code, input logic [SW-1:0] sw, input int press);
        int bd;
        int bw;
        switches = sw;
        tick(10);
        bd = done_cnt;
        bw = write_cnt;
        a7 = code;
        a0 = DW'($urandom);
        ecall = 1'b1;
        tick(3);
        n_checks++; if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL read_early_done: got %0d, expected 0", done_cnt - bd); end
        button = 1'b1;
        tick(press);
        button = 1'b0;
        tick(15);
        exp_res = read_model(code, sw);
        exp_seg = exp_res;
        n_checks++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL read_done_count: got %0d, expected 1", done_cnt - bd); end
        n_checks++; if (write_cnt - bw !== 1) begin n_fail++; $display("FAIL read_write_count: got %0d, expected 1", write_cnt - bw); end
        n_checks++; if (last_result !== exp_res) begin n_fail++; $display("FAIL read_result: got %h, expected %h", last_result, exp_res); end
        n_checks++; if (ecall_result !== exp_res) begin n_fail++; $display("FAIL read_result_hold: got %h, expected %h", ecall_result, exp_res); end
        n_checks++; if (seg_data !== exp_seg) begin n_fail++; $display("FAIL read_seg: got %h, expected %h", seg_data, exp_seg); end
        ecall = 1'b0;
        tick(10);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_idle: got %b, expected 0", busy); end
    endtask

    task automatic test_held_button();
        int bd;
        switches = 8'h5A;
        button = 1'b1;
        tick(12);
        bd = done_cnt;
        a7 = 32'd5;
        ecall = 1'b1;
        tick(15);
        n_checks++; if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL held_no_done: got %0d, expected 0", done_cnt - bd); end
        button = 1'b0;
        tick(12);
        n_checks++; if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL release_no_done: got %0d, expected 0", done_cnt - bd); end
        button = 1'b1;
        tick(2);
        button = 1'b0;
        tick(12);
        n_checks++; if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL glitch_no_done: got %0d, expected 0", done_cnt - bd); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_busy: got %b, expected 1", busy); end
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(15);
        exp_res = read_model(5, 8'h5A);
        exp_seg = exp_res;
        n_checks++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL held_final_done: got %0d, expected 1", done_cnt - bd); end
        n_checks++; if (ecall_result !== exp_res) begin n_fail++; $display("FAIL held_final_result: got %h, expected %h", ecall_result, exp_res); end
        ecall = 1'b0;
        tick(10);
    endtask

    task automatic test_unknown(input logic [DW-1:0] code);
        int bw;
        bw = write_cnt;
        a7 = code;
        a0 = DW'($urandom);
        ecall = 1'b1;
        tick(1);
        n_checks++; if (ecall_done !== 1'b1) begin n_fail++; $display("FAIL unknown_done: got %b, expected 1 (code %0d)", ecall_done, code); end
        n_checks++; if (bad_ecall !== 1'b1) begin n_fail++; $display("FAIL unknown_bad: got %b, expected 1", bad_ecall); end
        tick(1);
        ecall = 1'b0;
        tick(2);
        n_checks++; if (write_cnt - bw !== 0) begin n_fail++; $display("FAIL unknown_write: got %0d, expected 0", write_cnt - bw); end
        n_checks++; if (seg_data !== exp_seg) begin n_fail++; $display("FAIL unknown_seg: got %h, expected %h", seg_data, exp_seg); end
        n_checks++; if (ecall_result !== exp_res) begin n_fail++; $display("FAIL unknown_result_hold: got %h, expected %h", ecall_result, exp_res); end
    endtask

    task automatic test_cycle_code();
        int bw;
        apply_reset();
        while (cyc < 100) tick(1);
        bw = write_cnt;
        a7 = 32'd30;
        ecall = 1'b1;
`ifdef CYCLE_COUNTER_EN
        exp_res = cyc;
`endif
        tick(1);
        n_checks++; if (ecall_done !== 1'b1) begin n_fail++; $display("FAIL cyc_done: got %b, expected 1", ecall_done); end
`ifdef CYCLE_COUNTER_EN
        n_checks++; if (ecall_write !== 1'b1) begin n_fail++; $display("FAIL cyc_write: got %b, expected 1", ecall_write); end
        n_checks++; if (ecall_result !== exp_res) begin n_fail++; $display("FAIL cyc_value: got %0d, expected %0d", ecall_result, exp_res); end
        n_checks++; if (bad_ecall !== 1'b0) begin n_fail++; $display("FAIL cyc_bad: got %b, expected 0", bad_ecall); end
`else
        n_checks++; if (bad_ecall !== 1'b1) begin n_fail++; $display("FAIL cyc_bad: got %b, expected 1", bad_ecall); end
        n_checks++; if (write_cnt - bw !== 0) begin n_fail++; $display("FAIL cyc_write: got %0d, expected 0", write_cnt - bw); end
`endif
        ecall = 1'b0;
        tick(3);
    endtask

    task automatic test_exit();
        int bd;
        bd = done_cnt;
        a7 = 32'd10;
        ecall = 1'b1;
        tick(1);
        n_checks++; if ({halted, busy} !== 2'b11) begin n_fail++; $display("FAIL exit_status: got %b, expected 11", {halted, busy}); end
        for (int i = 0; i < 20; i++) begin
            ecall = 1'($urandom);
            a7 = 32'd1;
            tick(1);
        end
        n_checks++; if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL exit_no_done: got %0d, expected 0", done_cnt - bd); end
        n_checks++; if ({halted, busy} !== 2'b11) begin n_fail++; $display("FAIL exit_sticky: got %b, expected 11", {halted, busy}); end
        n_checks++; if (seg_data !== exp_seg) begin n_fail++; $display("FAIL exit_seg: got %h, expected %h", seg_data, exp_seg); end
        apply_reset();
        n_checks++; if ({halted, busy, bad_ecall} !== 3'b000) begin n_fail++; $display("FAIL exit_reset: got %b, expected 000", {halted, busy, bad_ecall}); end
        n_checks++; if (seg_data !== '0) begin n_fail++; $display("FAIL exit_reset_seg: got %h, expected 0", seg_data); end
    endtask

    task automatic test_reset_mid_wait();
        int bd;
        bd = done_cnt;
        switches = 8'hC3;
        a7 = 32'd6;
        ecall = 1'b1;
        tick(3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midwait_busy: got %b, expected 1", busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ecall = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midwait_reset_idle: got %b, expected 0", busy); end
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(10);
        n_checks++; if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL midwait_no_done: got %0d, expected 0", done_cnt - bd); end
    endtask

    initial begin
        logic [DW-1:0] code;
        int            rc;
        test_reset();
        test_print(32'h0000_BEEF);
        for (int i = 0; i < 3; i++) test_print(DW'($urandom));
        test_read(6, 8'hF3, 10);
        test_read(5, 8'hF3, 10);
        for (int i = 0; i < 4; i++) begin
            rc = ($urandom_range(0, 1) == 0) ? 5 : 6;
            test_read(rc, SW'($urandom), 10);
        end
        test_held_button();
        test_unknown(32'd7);
        for (int i = 0; i < 3; i++) begin
            code = DW'($urandom);
            while (code == 1 || code == 5 || code == 6 || code == 10 || code == 30) code = DW'($urandom);
            test_unknown(code);
        end
        test_print(DW'($urandom));
        n_checks++; if (bad_ecall !== 1'b1) begin n_fail++; $display("FAIL bad_sticky: got %b, expected 1", bad_ecall); end
        test_cycle_code();
        test_exit();
        test_reset_mid_wait();
        n_checks++; if (orphan_write !== 0) begin n_fail++; $display("FAIL write_without_done: got %0d, expected 0", orphan_write); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
